vram_arbiter: RTL and testbench

- Shares the single-port VRAM (128x128 words, 14-bit address {row,col}) between the VGA display fetch path and a pixel-writer requester (pattern generator / UART loader).
- Display reads have strict priority. Writes are held in a one-entry buffer and committed in blanking cycles.
- Sits between the display address mux, the writer, and the VRAM macro. Also produces the registered pixel value sent to the colour outputs.

---
 rtl/vram_arbiter.sv | 156 +++++++++++++++
 tb/tb_vram_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares a single-port 128x128 VRAM between the display fetch path and a
// pixel writer. Display reads always win. A write is parked in a one-entry
// buffer and committed during a blanking cycle. The block also produces the
// registered pixel that feeds the colour outputs.
//
// Optional feature (macro STEAL_EN): a write that has waited MAX_WAIT-1
// display-active cycles takes the next active cycle ("steal"). That slot's
// pixel is shown as BLACK_VALUE.
//
// Ports:
//   clk          system / pixel clock
//   reset_n      asynchronous active-low reset
//   disp_active  high while H and V are both in the visible region
//   disp_addr    display read address {row, col}
//   wr_req       writer request; must stay high until accepted
//   wr_addr      write address
//   wr_data      write data
//   wr_ready     buffer empty; request accepted at this edge if wr_req=1
//   wr_done      one-cycle pulse after the write reached VRAM
//   vram_addr    VRAM address
//   vram_we      VRAM write enable
//   vram_din     VRAM write data (always the buffered data)
//   vram_dout    VRAM read data, one-cycle synchronous read latency
//   pix_data     registered pixel for the colour outputs
//   wait_cnt     cycles the pending write has waited (saturates at 255)
//   dbg_state    current FSM state (0 = IDLE, 1 = PEND)
//
// Writer handshake: a write transfers at a rising clk edge where wr_req and
// wr_ready are both high. The writer holds wr_req, wr_addr and wr_data stable
// until that edge; wr_req while wr_ready is low is ignored.
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int          DATA_W      = 3,
    parameter logic [13:0] BLACK_ADDR  = 14'h24F6,
    parameter int          BLACK_VALUE = 0,
    parameter int          MAX_WAIT    = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disp_active,
    input  logic [13:0]       disp_addr,
    input  logic              wr_req,
    input  logic [13:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              wr_done,
    output logic [13:0]       vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_din,
    input  logic [DATA_W-1:0] vram_dout,
    output logic [DATA_W-1:0] pix_data,
    output logic [7:0]        wait_cnt,
    output logic              dbg_state
);

    localparam logic [DATA_W-1:0] BLACK_PIX = DATA_W'(BLACK_VALUE);
    localparam logic [7:0]        WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t            state_q;
    logic [13:0]       h_addr_q;
    logic [DATA_W-1:0] h_data_q;
    logic              wr_done_q;
    logic [7:0]        wait_cnt_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] pix_data_q;

    logic              steal;
    logic              commit;
    logic [7:0]        wait_cnt_d;

`ifdef STEAL_EN
    // The pending write has already waited MAX_WAIT-1 active cycles; this
    // active cycle goes to the writer instead of the display.
    assign steal = (state_q == PEND) && disp_active && (wait_cnt_q == WAIT_LAST);
`else
    // Without stealing, blanking is the only commit opportunity.
    logic unused_wait_last;
    assign unused_wait_last = ^WAIT_LAST;
    assign steal = 1'b0;
`endif

    assign commit = (state_q == PEND) && (!disp_active || steal);

    // Saturating increment of the wait counter.
    assign wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;

    // VRAM port mux. Reset forces the idle address so the macro sees no
    // activity while the arbiter is held in reset.
    always_comb begin
        vram_we   = 1'b0;
        vram_addr = BLACK_ADDR;
        if (reset_n) begin
            if (commit) begin
                vram_we   = 1'b1;
                vram_addr = h_addr_q;
            end else if (disp_active) begin
                vram_addr = disp_addr;
            end
        end
    end

    assign vram_din  = h_data_q;
    assign wr_ready  = (state_q == IDLE);
    assign wr_done   = wr_done_q;
    assign wait_cnt  = wait_cnt_q;
    assign pix_data  = pix_data_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            h_addr_q   <= '0;
            h_data_q   <= '0;
            wr_done_q  <= 1'b0;
            wait_cnt_q <= '0;
            rd_valid_q <= 1'b0;
            pix_data_q <= BLACK_PIX;
        end else begin
            wr_done_q  <= 1'b0;
            // A stolen slot carries no display data.
            rd_valid_q <= disp_active && !steal;
            pix_data_q <= rd_valid_q ? vram_dout : BLACK_PIX;

            case (state_q)
                IDLE: begin
                    wait_cnt_q <= '0;
                    if (wr_req) begin
                        h_addr_q <= wr_addr;
                        h_data_q <= wr_data;
                        state_q  <= PEND;
                    end
                end
                PEND: begin
                    if (commit) begin
                        wr_done_q  <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= IDLE;
                    end else begin
                        // Staying in PEND implies an active display cycle.
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

    localparam int          DW         = 3;
    localparam logic [13:0] BLACK_ADDR = 14'h24F6;
    localparam logic [DW-1:0] BLACK_PIX = '0;
    localparam int          MAX_WAIT   = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          disp_active;
    logic [13:0]   disp_addr;
    logic          wr_req;
    logic [13:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          wr_done;
    logic [13:0]   vram_addr;
    logic          vram_we;
    logic [DW-1:0] vram_din;
    logic [DW-1:0] vram_dout;
    logic [DW-1:0] pix_data;
    logic [7:0]    wait_cnt;
    logic          dbg_state;

    vram_arbiter #(
        .DATA_W(DW), .BLACK_ADDR(BLACK_ADDR), .BLACK_VALUE(0), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .disp_active(disp_active), .disp_addr(disp_addr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_done(wr_done),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_din(vram_din),
        .vram_dout(vram_dout), .pix_data(pix_data), .wait_cnt(wait_cnt),
        .dbg_state(dbg_state)
    );

    // ---------------- VRAM macro stand-in (sync read, 1 cycle) ----------------
    logic [DW-1:0] mem [0:16383];
    logic          mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16384; i++) mem[i] <= '0;
        end else if (vram_we) begin
            mem[vram_addr] <= vram_din;
        end
        vram_dout <= mem[vram_addr];
    end

    // ---------------- reference model state ----------------
    logic [DW-1:0] shadow [0:16383];   // what VRAM should contain
    bit            m_pend;             // a write is held
    logic [13:0]   m_addr;
    logic [DW-1:0] m_data;
    int            m_waited;           // active cycles the held write has waited
    bit            m_done;             // commit happened last cycle
    logic [DW-1:0] exp_q[$];           // pixel pipeline: head is due this cycle

    // writer-side request queue
    logic [13:0]   wq_addr[$];
    logic [DW-1:0] wq_data[$];

    int checks;
    int failures;

    // ---------------- scoreboard ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend   = 0;
        m_addr   = '0;
        m_data   = '0;
        m_waited = 0;
        m_done   = 0;
        exp_q.delete();
        exp_q.push_back(BLACK_PIX);
        exp_q.push_back(BLACK_PIX);
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic push_write(input logic [13:0] a, input logic [DW-1:0] d);
        wq_addr.push_back(a);
        wq_data.push_back(d);
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Entered just after a rising edge. Drives inputs, checks every output
    // against the model, advances through the next edge.
    task automatic cycle(input bit act, input logic [13:0] daddr);
        bit          steal;
        bit          commit;
        bit          acc;
        logic [13:0] e_addr;
        disp_active = act;
        disp_addr   = daddr;
        wr_req      = (wq_addr.size() > 0);
        if (wr_req) begin
            wr_addr = wq_addr[0];
            wr_data = wq_data[0];
        end
        #1;
        steal = 0;
`ifdef STEAL_EN
        steal = m_pend && act && (m_waited == MAX_WAIT - 1);
`endif
        commit = m_pend && (!act || steal);
        e_addr = commit ? m_addr : (act ? daddr : BLACK_ADDR);
        check_val("wr_ready",  wr_ready,  !m_pend);
        check_val("dbg_state", dbg_state, m_pend);
        check_val("wr_done",   wr_done,   m_done);
        check_val("vram_we",   vram_we,   commit);
        check_val("vram_addr", vram_addr, e_addr);
        check_val("vram_din",  vram_din,  m_data);
        check_val("wait_cnt",  wait_cnt,  m_pend ? m_waited : 0);
        check_val("pix_data",  pix_data,  exp_q[0]);
        exp_q.push_back((act && !steal) ? shadow[daddr] : BLACK_PIX);
        acc = wr_req && wr_ready;
        @(posedge clk);
        exp_q.pop_front();
        m_done = commit;
        if (!m_pend) begin
            if (wr_req) begin
                m_pend   = 1;
                m_addr   = wr_addr;
                m_data   = wr_data;
                m_waited = 0;
            end
        end else if (commit) begin
            shadow[m_addr] = m_data;
            m_pend = 0;
        end else if (m_waited < 255) begin
            m_waited++;
        end
        if (acc) begin
            void'(wq_addr.pop_front());
            void'(wq_data.pop_front());
        end
        #1;
    endtask

    // Reset asserted in the middle of a cycle while a write is held.
    task automatic mid_reset();
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_wr_ready",  wr_ready,  1);
        check_val("rst_wr_done",   wr_done,   0);
        check_val("rst_vram_we",   vram_we,   0);
        check_val("rst_vram_addr", vram_addr, BLACK_ADDR);
        check_val("rst_pix_data",  pix_data,  BLACK_PIX);
        check_val("rst_wait_cnt",  wait_cnt,  0);
        wr_req = 1'b0;
        @(posedge clk);
        #3;
        check_val("rst_hold_we", vram_we, 0);
        model_reset();
        reset_n = 1'b1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int  run_left;
        bit  act;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 16384; i++) shadow[i] = '0;
        reset_n     = 1'b0;
        disp_active = 1'b0;
        disp_addr   = '0;
        wr_req      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        mem_clr     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_clr = 1'b0;

        // Reset state, with display and writer both trying to use VRAM.
        disp_active = 1'b1;
        disp_addr   = 14'h0123;
        wr_req      = 1'b1;
        #1;
        check_val("reset_wr_ready",  wr_ready,  1);
        check_val("reset_wr_done",   wr_done,   0);
        check_val("reset_pix_data",  pix_data,  BLACK_PIX);
        check_val("reset_wait_cnt",  wait_cnt,  0);
        check_val("reset_vram_we",   vram_we,   0);
        check_val("reset_vram_addr", vram_addr, BLACK_ADDR);
        wr_req      = 1'b0;
        disp_active = 1'b0;
        model_reset();
        reset_n = 1'b1;

        // Single blanking write, then read it back through the display path.
        push_write(14'h0105, 3'b101);
        repeat (4) cycle(0, 14'h0000);
        cycle(1, 14'h0105);
        repeat (3) cycle(0, 14'h0000);

        // Four back-to-back writes in blanking, then display steps over them.
        for (int i = 0; i < 4; i++) push_write(14'(i), DW'(i + 1));
        repeat (10) cycle(0, 14'h0000);
        for (int i = 0; i < 4; i++) cycle(1, 14'(i));
        repeat (3) cycle(0, 14'h0000);

        // Write requested at the start of a 100-cycle active region.
        push_write(14'h0300, 3'b110);
        cycle(1, 14'h0001);
        for (int i = 0; i < 100; i++) cycle(1, 14'(i % 4));
        repeat (4) cycle(0, 14'h0000);

        // Long active region: wait counter saturation (or a steal).
        push_write(14'h0301, 3'b011);
        for (int i = 0; i < 300; i++) cycle(1, 14'(i % 4));
        repeat (3) cycle(0, 14'h0000);
        cycle(1, 14'h0300);
        cycle(1, 14'h0301);
        repeat (3) cycle(0, 14'h0000);

        // Reset while a write is held: it must never reach VRAM.
        push_write(14'h0200, 3'b111);
        cycle(1, 14'h0002);
        cycle(1, 14'h0003);
        mid_reset();
        repeat (4) cycle(0, 14'h0000);
        cycle(1, 14'h0200);
        repeat (3) cycle(0, 14'h0000);

        // Randomized traffic: alternating active/blanking runs.
        run_left = 0;
        act      = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_left == 0) begin
                act      = !act;
                run_left = act ? $urandom_range(1, 90) : $urandom_range(1, 8);
            end
            run_left--;
            if (wq_addr.size() < 3 && $urandom_range(0, 3) == 0)
                push_write(14'($urandom_range(0, 15)), DW'($urandom));
            cycle(act, 14'($urandom_range(0, 15)));
        end
        repeat (6) cycle(0, 14'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
